// File: rtl/alu_cmd_driver.sv
// Initiator for a 4-bit combinational ALU: queues commands, drives registered A/B/Sel,
// captures the 8-bit result and returns it over a valid/ready stream. Optional macro: ALU_CMD_CHAIN_EN.
module alu_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_op,
`ifdef ALU_CMD_CHAIN_EN
  input  logic       cmd_chain,
`endif
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_c,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_op,
  output logic       res_err,
  output logic       busy
);

  // Handshakes: a beat transfers on the rising edge where valid & ready are both high;
  // the producer holds its payload stable until then, and ready never depends on valid.

`ifdef ALU_CMD_CHAIN_EN
  localparam int ENT_W = 13;
`else
  localparam int ENT_W = 12;
`endif

  localparam logic [PTR_W:0]   C_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [3:0]       r_alu_a;
  logic [3:0]       r_alu_b;
  logic [3:0]       r_alu_sel;
  logic             r_res_valid;
  logic [7:0]       r_res_data;
  logic [3:0]       r_res_op;
  logic             r_res_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_issue;
  logic [ENT_W-1:0] w_push_ent;
  logic [ENT_W-1:0] w_head;
  logic [3:0]       w_issue_a;

  function automatic logic is_illegal(input logic [3:0] op);
    logic bad;
    case (op)
      4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100,
      4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b0101: bad = 1'b0;
      default:                                     bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign w_full    = (r_count == C_FULL);
  assign w_empty   = (r_count == '0);
  assign cmd_ready = rst_n && !w_full;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_head    = r_mem[r_rd_ptr];

  // Issue from IDLE, or straight from RESP in the same cycle the result is taken.
  assign w_issue = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_RESP) && res_ready));

`ifdef ALU_CMD_CHAIN_EN
  assign w_push_ent = {cmd_chain, cmd_a, cmd_b, cmd_op};
  // r_res_data still holds the last completed result when the next command issues.
  assign w_issue_a  = w_head[12] ? r_res_data[3:0] : w_head[11:8];
`else
  assign w_push_ent = {cmd_a, cmd_b, cmd_op};
  assign w_issue_a  = w_head[11:8];
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
      r_res_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_alu_a   <= w_issue_a;
            r_alu_b   <= w_head[7:4];
            r_alu_sel <= w_head[3:0];
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res_data  <= alu_c;
          r_res_op    <= r_alu_sel;
          r_res_err   <= is_illegal(r_alu_sel);
          r_res_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_issue) begin
              r_alu_a   <= w_issue_a;
              r_alu_b   <= w_head[7:4];
              r_alu_sel <= w_head[3:0];
              r_state   <= S_EXEC;
            end else begin
              r_state   <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign res_err   = r_res_err;
  assign busy      = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: an ALU model closes the loop on alu_c, and an in-order
// result queue predicts every returned result from the accepted commands.
module tb_alu_cmd_driver;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] cmd_op;
`ifdef ALU_CMD_CHAIN_EN
  logic       cmd_chain;
`endif
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_c;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_op;
  logic       res_err;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected result queue entries: {op[12:9], data[8:1], err[0]}.
  logic [12:0] exp_q[$];
  logic [7:0]  m_last;

  alu_cmd_driver #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
`ifdef ALU_CMD_CHAIN_EN
    .cmd_chain (cmd_chain),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_c     (alu_c),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_err   (res_err),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- ALU model ----------------
  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'b0000, a};
    eb = {4'b0000, b};
    case (op)
      4'b0000: return ea + eb;
      4'b1111: return ea - eb;
      4'b0001: return ea & eb;
      4'b0010: return ea | eb;
      4'b0100: return ea ^ eb;
      4'b1000: return (a == b) ? 8'hFF : 8'h00;
      4'b0011: return (a > b)  ? 8'hFF : 8'h00;
      4'b0110: return ea << b;
      4'b1100: return ea >> b;
      4'b0101: return ea * eb;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return !(op inside {4'b0000, 4'b1111, 4'b0001, 4'b0010, 4'b0100,
                        4'b1000, 4'b0011, 4'b0110, 4'b1100, 4'b0101});
  endfunction

  always_comb alu_c = alu_fn(alu_a, alu_b, alu_sel);

  // ---------------- checker ----------------
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic [3:0]  a_eff;
    logic [7:0]  r;
    logic [12:0] front;
    if (!rst_n) begin
      exp_q.delete();
      m_last = 8'h00;
    end else begin
      chk("busy_vs_outstanding", int'(busy), int'(exp_q.size() != 0));
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          front = exp_q[0];
          chk("res_op",   int'(res_op),   int'(front[12:9]));
          chk("res_data", int'(res_data), int'(front[8:1]));
          chk("res_err",  int'(res_err),  int'(front[0]));
          if (res_ready) void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) begin
        a_eff = cmd_a;
`ifdef ALU_CMD_CHAIN_EN
        if (cmd_chain) a_eff = m_last[3:0];
`endif
        r = alu_fn(a_eff, cmd_b, cmd_op);
        exp_q.push_back({cmd_op, r, op_illegal(cmd_op)});
        m_last = r;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic drv_chain = 1'b0;

  task automatic rand_payload();
    cmd_a  = 4'($urandom_range(0, 15));
    cmd_b  = 4'($urandom_range(0, 15));
    cmd_op = 4'($urandom_range(0, 15));
`ifdef ALU_CMD_CHAIN_EN
    cmd_chain = 1'($urandom_range(0, 1));
`endif
  endtask

  // One command from an idle, empty block; pins the exact latency and result.
  task automatic single(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic [3:0] exp_a, input logic [7:0] exp_d,
                        input logic exp_e, input string nm);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
`ifdef ALU_CMD_CHAIN_EN
    cmd_chain = drv_chain;
`endif
    chk({nm, "_ready"}, int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid_n0"}, int'(res_valid), 0);
    @(negedge clk);
    chk({nm, "_valid_n1"}, int'(res_valid), 0);
    chk({nm, "_alu_a"},   int'(alu_a),   int'(exp_a));
    chk({nm, "_alu_b"},   int'(alu_b),   int'(b));
    chk({nm, "_alu_sel"}, int'(alu_sel), int'(op));
    @(negedge clk);
    chk({nm, "_valid_n2"}, int'(res_valid), 1);
    chk({nm, "_data"},     int'(res_data),  int'(exp_d));
    chk({nm, "_op"},       int'(res_op),    int'(op));
    chk({nm, "_err"},      int'(res_err),   int'(exp_e));
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done_valid"}, int'(res_valid), 0);
    chk({nm, "_done_busy"},  int'(busy),      0);
  endtask

  // Offer random commands back-to-back until n are accepted or the budget runs out.
  task automatic push_n(input int n, input int budget, output int acc);
    logic took;
    acc = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    rand_payload();
    for (int c = 0; c < budget && acc < n; c++) begin
      @(negedge clk);
      took = cmd_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        rand_payload();
      end
    end
    cmd_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   acc;
    int   last;
    int   n;
    int   stale;
    logic took;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
`ifdef ALU_CMD_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_alu_a",     int'(alu_a),     0);
    chk("rst_alu_sel",   int'(alu_sel),   0);
    chk("rst_res_data",  int'(res_data),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);

    // Directed results with literal expectations.
    single(4'h3, 4'h5, 4'b0000, 4'h3, 8'h08, 1'b0, "sum");
`ifdef ALU_CMD_CHAIN_EN
    drv_chain = 1'b1;
    single(4'hA, 4'h1, 4'b0110, 4'h8, 8'h10, 1'b0, "chain_shl");
    drv_chain = 1'b0;
`endif
    single(4'h2, 4'h5, 4'b1111, 4'h2, 8'hFD, 1'b0, "sub");
    single(4'hF, 4'hF, 4'b0101, 4'hF, 8'hE1, 1'b0, "mul");
    single(4'h9, 4'h4, 4'b0011, 4'h9, 8'hFF, 1'b0, "gt");
    single(4'h6, 4'h6, 4'b0111, 4'h6, 8'h00, 1'b1, "illegal");
    single(4'h6, 4'h6, 4'b1000, 4'h6, 8'hFF, 1'b0, "eq");

    // Fill: DEPTH in the FIFO plus one held in RESP, then drain at one per 2 cycles.
    push_n(99, 12, acc);
    chk("fill_accepts", acc, DEPTH + 1);
    @(negedge clk);
    chk("fill_ready_low", int'(cmd_ready), 0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    last = -1;
    n = 0;
    for (int c = 0; c < 40 && n < DEPTH + 1; c++) begin
      @(negedge clk);
      if (res_valid) begin
        if (last >= 0) chk("drain_spacing", c - last, 2);
        last = c;
        n++;
      end
    end
    chk("drain_count", n, DEPTH + 1);
    @(posedge clk); #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("drain_idle_busy", int'(busy), 0);

    // Reset while a result waits in RESP and two commands are queued.
    push_n(3, 10, acc);
    chk("rstmid_accepts", acc, 3);
    n = 0;
    while (!res_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_resp_reached", int'(res_valid), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_res_valid", int'(res_valid), 0);
    chk("rstmid_busy",      int'(busy),      0);
    chk("rstmid_cmd_ready", int'(cmd_ready), 0);
    chk("rstmid_res_data",  int'(res_data),  0);
    chk("rstmid_res_op",    int'(res_op),    0);
    chk("rstmid_alu_b",     int'(alu_b),     0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_release_ready", int'(cmd_ready), 1);
    res_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) stale++;
    end
    chk("rstmid_no_stale", stale, 0);

    // Random traffic with random backpressure.
    cmd_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      took = cmd_valid && cmd_ready;
      @(posedge clk); #1;
      if (!cmd_valid || took) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        rand_payload();
      end
      res_ready = ($urandom_range(0, 2) != 0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_busy",        int'(busy),   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
